// File: rtl/seq_bin_to_bcd_if.sv
// Valid/ready bundle between a binary producer and the BCD converter.
interface seq_bin_to_bcd_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic [DIGITS-1:0]     blank;
  logic                  overflow;

  // Producer/consumer side: drives the value in and accepts the result
  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, blank, overflow
  );

  // Converter side
  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, blank, overflow
  );
endinterface

// File: rtl/seq_bin_to_bcd.sv
// Sequential binary-to-BCD converter: double dabble, one input bit per clock,
// with leading-zero blanking mask and saturating overflow.
module seq_bin_to_bcd #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic            clk,
  input  logic            reset,
  seq_bin_to_bcd_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [BW-1:0]    acc, acc_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             ovf_sticky, ovf_sticky_n;
  logic [BW-1:0]    bcd_q, bcd_n;
  logic [DIGITS-1:0] blank_q, blank_n;
  logic             ovf_q, ovf_n;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    acc_sh;
  logic             ovf_fin;
  logic [BW-1:0]    bcd_fin;
  logic [DIGITS-1:0] blank_fin;
  logic             all_zero;
  logic             in_ready_c;
  logic             accept;

  // Ready is combinational from out_ready so DONE can hand over back-to-back
  assign in_ready_c    = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && in_ready_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state == DONE);
  assign bus.bcd_out   = bcd_q;
  assign bus.blank     = blank_q;
  assign bus.overflow  = ovf_q;

  // Add-3 adjust on every digit >= 5, then shift the next binary bit in
  always_comb begin
    adj = acc;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_sh  = {adj[BW-2:0], sreg[WIDTH-1]};
    ovf_fin = ovf_sticky | adj[BW-1];
  end

  // Final result formatting: saturation to all nines and leading-zero mask
  always_comb begin
    all_zero  = 1'b1;
    blank_fin = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      if (acc_sh[4*i +: 4] != 4'd0) all_zero = 1'b0;
      blank_fin[i] = all_zero;
    end
    blank_fin[0] = 1'b0;
    bcd_fin      = acc_sh;
    if (ovf_fin) begin
      bcd_fin   = {DIGITS{4'h9}};
      blank_fin = '0;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_n      = state;
    sreg_n       = sreg;
    acc_n        = acc;
    cnt_n        = cnt;
    ovf_sticky_n = ovf_sticky;
    bcd_n        = bcd_q;
    blank_n      = blank_q;
    ovf_n        = ovf_q;

    case (state)
      IDLE: ;
      SHIFT: begin
        sreg_n       = {sreg[WIDTH-2:0], 1'b0};
        acc_n        = acc_sh;
        ovf_sticky_n = ovf_fin;
        cnt_n        = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = DONE;
          bcd_n   = bcd_fin;
          blank_n = blank_fin;
          ovf_n   = ovf_fin;
        end
      end
      DONE: begin
        if (bus.out_ready && !bus.in_valid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // A new value can be taken from IDLE or straight out of DONE
    if (accept) begin
      state_n      = SHIFT;
      sreg_n       = bus.bin_in;
      acc_n        = '0;
      ovf_sticky_n = 1'b0;
      cnt_n        = CW'(WIDTH);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sreg       <= '0;
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      bcd_q      <= '0;
      blank_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state      <= state_n;
      sreg       <= sreg_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      ovf_sticky <= ovf_sticky_n;
      bcd_q      <= bcd_n;
      blank_q    <= blank_n;
      ovf_q      <= ovf_n;
    end
  end

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Scoreboard bench for seq_bin_to_bcd: 16-bit/5-digit and 16-bit/4-digit instances.
module tb_seq_bin_to_bcd;

  typedef struct {
    logic [19:0] bcd;
    logic [4:0]  blank;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  exp_t q5[$];
  exp_t q4[$];

  seq_bin_to_bcd_if #(.WIDTH(16), .DIGITS(5)) bus5 ();
  seq_bin_to_bcd_if #(.WIDTH(16), .DIGITS(4)) bus4 ();

  seq_bin_to_bcd #(.WIDTH(16), .DIGITS(5)) u_dut5 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus5)
  );

  seq_bin_to_bcd #(.WIDTH(16), .DIGITS(4)) u_dut4 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the 5-digit instance
  always @(negedge clk) begin
    if (!rst && bus5.out_valid && bus5.out_ready) begin
      if (q5.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL d5_unexpected: result 0x%0h with empty queue", bus5.bcd_out);
      end else begin
        exp_t e;
        e = q5.pop_front();
        check("d5_bcd", 32'(bus5.bcd_out), 32'(e.bcd));
        check("d5_blank", 32'(bus5.blank), 32'(e.blank));
        check("d5_ovf", 32'(bus5.overflow), 32'(e.ovf));
      end
    end
  end

  // Monitor for the 4-digit instance
  always @(negedge clk) begin
    if (!rst && bus4.out_valid && bus4.out_ready) begin
      if (q4.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL d4_unexpected: result 0x%0h with empty queue", bus4.bcd_out);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("d4_bcd", 32'(bus4.bcd_out), 32'(e.bcd));
        check("d4_blank", 32'(bus4.blank), 32'(e.blank));
        check("d4_ovf", 32'(bus4.overflow), 32'(e.ovf));
      end
    end
  end

  // Present one value and push its expected result once accepted
  task automatic send(input int sel, input logic [15:0] v, input logic [19:0] eb,
                      input logic [4:0] ebl, input logic eo);
    exp_t e;
    int   n;
    logic rdy;
    e.bcd   = eb;
    e.blank = ebl;
    e.ovf   = eo;
    if (sel == 0) begin
      bus5.in_valid = 1'b1;
      bus5.bin_in   = v;
    end else begin
      bus4.in_valid = 1'b1;
      bus4.bin_in   = v;
    end
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = (sel == 0) ? bus5.in_ready : bus4.in_ready;
      n++;
    end
    if (!rdy) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: value %0d never accepted", v);
    end else if (sel == 0) begin
      q5.push_back(e);
    end else begin
      q4.push_back(e);
    end
    @(posedge clk);
    #1;
    bus5.in_valid = 1'b0;
    bus4.in_valid = 1'b0;
    bus5.bin_in   = 16'hDEAD;
    bus4.bin_in   = 16'hBEEF;
  endtask

  // Count edges from acceptance until the 5-digit result is presented
  task automatic wait_valid(output int k);
    k = 0;
    while (k < 100) begin
      @(posedge clk);
      #1;
      k++;
      if (bus5.out_valid) break;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q5.size() != 0 || q4.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (q5.size() != 0 || q4.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding", q5.size() + q4.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus5.in_valid  = 1'b0;
    bus5.bin_in    = '0;
    bus5.out_ready = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.bin_in    = '0;
    bus4.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus5.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus5.out_valid), 32'd0);
    check("rst_bcd", 32'(bus5.bcd_out), 32'd0);
    check("rst_blank", 32'(bus5.blank), 32'd0);
    check("rst_ovf", 32'(bus5.overflow), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero, with exact latency
    send(0, 16'd0, 20'h00000, 5'b11110, 1'b0);
    wait_valid(k);
    check("latency_zero", 32'(k), 32'd16);
    drain();

    // Directed 5-digit values, issued back to back
    send(0, 16'd65535, 20'h65535, 5'b00000, 1'b0);
    send(0, 16'd907,   20'h00907, 5'b11000, 1'b0);
    send(0, 16'd1,     20'h00001, 5'b11110, 1'b0);
    send(0, 16'd10,    20'h00010, 5'b11100, 1'b0);
    send(0, 16'd9,     20'h00009, 5'b11110, 1'b0);
    send(0, 16'd100,   20'h00100, 5'b11000, 1'b0);
    send(0, 16'd10000, 20'h10000, 5'b00000, 1'b0);
    send(0, 16'd12345, 20'h12345, 5'b00000, 1'b0);
    drain();

    // 4-digit instance: saturation boundary
    send(1, 16'd12345, 20'h09999, 5'b00000, 1'b1);
    send(1, 16'd9999,  20'h09999, 5'b00000, 1'b0);
    send(1, 16'd10000, 20'h09999, 5'b00000, 1'b1);
    send(1, 16'd65535, 20'h09999, 5'b00000, 1'b1);
    send(1, 16'd1000,  20'h01000, 5'b00000, 1'b0);
    send(1, 16'd999,   20'h00999, 5'b01000, 1'b0);
    send(1, 16'd0,     20'h00000, 5'b01110, 1'b0);
    drain();

    // Backpressure hold, then back-to-back hand-over
    bus5.out_ready = 1'b0;
    send(0, 16'd907, 20'h00907, 5'b11000, 1'b0);
    wait_valid(k);
    check("latency_907", 32'(k), 32'd16);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus5.out_valid), 32'd1);
      check("hold_bcd", 32'(bus5.bcd_out), 32'h00907);
      check("hold_blank", 32'(bus5.blank), 32'(5'b11000));
      check("hold_in_ready", 32'(bus5.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus5.out_ready = 1'b1;
    send(0, 16'd42, 20'h00042, 5'b11100, 1'b0);
    wait_valid(k);
    check("latency_b2b", 32'(k), 32'd16);
    drain();

    // Asynchronous reset in the middle of a conversion
    send(0, 16'd12345, 20'h12345, 5'b00000, 1'b0);
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    q5.delete(q5.size() - 1);
    #1;
    check("mid_rst_out_valid", 32'(bus5.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus5.in_ready), 32'd1);
    check("mid_rst_bcd", 32'(bus5.bcd_out), 32'd0);
    check("mid_rst_blank", 32'(bus5.blank), 32'd0);
    check("mid_rst_ovf", 32'(bus5.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(0, 16'd100, 20'h00100, 5'b11000, 1'b0);
    drain();

    check("queues_empty", 32'(q5.size() + q4.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
